// File: rtl/modport_ahb_slave_pkg.sv
// -----------------------------------------------------------------------------
// modport_ahb_pkg
// Shared AHB3-Lite types and constants for the modport_ahb_slave memory slave:
// transfer type, size and burst encodings, the response constants, the
// response FSM state type, and a byte-lane helper used by the RAM write path.
// -----------------------------------------------------------------------------
package modport_ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    BYTE  = 3'd0,
    HWORD = 3'd1,
    WORD  = 3'd2
  } hsize_e;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } hburst_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // WAIT_ST is only reachable in the wait-state build.
  typedef enum logic [1:0] {
    OKAY_ST = 2'd0,
    ERR1    = 2'd1,
    ERR2    = 2'd2,
    WAIT_ST = 2'd3
  } resp_state_e;

  // Byte lanes touched by a legal (aligned, size <= word) transfer.
  function automatic logic [3:0] byte_lanes(hsize_e size, logic [1:0] addr);
    logic [3:0] lanes;
    case (size)
      BYTE:    lanes = 4'b0001 << addr;
      HWORD:   lanes = addr[1] ? 4'b1100 : 4'b0011;
      default: lanes = 4'b1111;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/modport_ahb_slave_if.sv
// -----------------------------------------------------------------------------
// modport_ahb_slave_if
// AHB3-Lite bus bundle between a master (or interconnect) and one slave.
//   master modport: drives HSELx, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT,
//                   HTRANS, HREADY; observes HRDATA, HREADYOUT, HRESP.
//   slave  modport: the mirror image.
// -----------------------------------------------------------------------------
interface modport_ahb_slave_if #(
  parameter int unsigned HADDR_SIZE = 32,
  parameter int unsigned HDATA_SIZE = 32
);
  logic                  HSELx;
  logic [HADDR_SIZE-1:0] HADDR;
  logic [HDATA_SIZE-1:0] HWDATA;
  logic [HDATA_SIZE-1:0] HRDATA;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [1:0]            HTRANS;
  logic                  HREADYOUT;
  logic                  HREADY;
  logic                  HRESP;

  modport master (
    output HSELx, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSELx, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/modport_ahb_slave_mem.sv
// -----------------------------------------------------------------------------
// modport_ahb_mem
// Word-organised RAM with per-byte write enables, synchronous write and
// asynchronous read. Contents are not reset.
//   clk_i   : clock
//   we_i    : write enable
//   be_i    : byte enables (bit n = bits 8n+7:8n)
//   idx_i   : word index (shared by read and write)
//   wdata_i : write data
//   rdata_o : read data, combinational from idx_i
// -----------------------------------------------------------------------------
module modport_ahb_mem #(
  parameter  int unsigned MEM_DEPTH = 256,
  localparam int unsigned IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [3:0]       be_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/modport_ahb_slave.sv
// -----------------------------------------------------------------------------
// modport_ahb_slave
// AHB3-Lite single-port memory slave: zero-wait word-addressed RAM with a
// two-cycle ERROR response for oversize, misaligned or out-of-range transfers.
//   HCLK    : clock, rising edge
//   HRESETn : synchronous reset, ACTIVE HIGH despite the name
//   ahb     : slave modport of modport_ahb_slave_if (address/data/response)
// Build option: define MODPORT_AHB_SLAVE_WAIT_STATE_EN to insert exactly one
// wait state into every OKAY data phase; error responses are unaffected.
// -----------------------------------------------------------------------------
module modport_ahb_slave
  import modport_ahb_pkg::*;
#(
  parameter int unsigned HADDR_SIZE = 32,
  parameter int unsigned HDATA_SIZE = 32,
  parameter int unsigned MEM_DEPTH  = 256
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  modport_ahb_slave_if.slave ahb
);

  localparam int unsigned           IDX_W      = $clog2(MEM_DEPTH);
  localparam logic [HADDR_SIZE-1:0] ADDR_LIMIT = HADDR_SIZE'(MEM_DEPTH * 4);

  resp_state_e      state_q, state_d;
  logic             valid_q;
  logic             write_q;
  hsize_e           size_q;
  logic [IDX_W+1:0] addr_q;
  logic [31:0]      rdata_hold_q;

  logic             trans_active, accept, misaligned, xfer_err;
  logic             hreadyout, hresp;
  logic             dp_done, rd_done, mem_we;
  logic [31:0]      mem_rdata;
  logic             unused_ok;

  assign unused_ok = ^{ahb.HBURST, ahb.HPROT};

  // Address-phase decode
  always_comb begin
    trans_active = (htrans_e'(ahb.HTRANS) == NONSEQ) || (htrans_e'(ahb.HTRANS) == SEQ);
    accept       = ahb.HSELx & ahb.HREADY & trans_active;
    misaligned   = ((ahb.HSIZE == HWORD) && ahb.HADDR[0]) ||
                   ((ahb.HSIZE == WORD) && (ahb.HADDR[1:0] != 2'b00));
    xfer_err     = (ahb.HSIZE > 3'd2) | misaligned | (ahb.HADDR >= ADDR_LIMIT);
  end

  // Response FSM, next state and outputs
  always_comb begin
    state_d   = state_q;
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    case (state_q)
      OKAY_ST: begin
        if (accept & xfer_err) state_d = ERR1;
`ifdef MODPORT_AHB_SLAVE_WAIT_STATE_EN
        else if (accept) state_d = WAIT_ST;
`endif
      end
      WAIT_ST: begin
        hreadyout = 1'b0;
        state_d   = OKAY_ST;
      end
      ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
        state_d   = ERR2;
      end
      ERR2: begin
        hresp = HRESP_ERROR;
        if (accept & xfer_err) state_d = ERR1;
`ifdef MODPORT_AHB_SLAVE_WAIT_STATE_EN
        else if (accept) state_d = WAIT_ST;
`endif
        else state_d = OKAY_ST;
      end
    endcase
  end

  // Only error-free transfers open a data phase; valid_q therefore implies
  // the FSM is in OKAY_ST or WAIT_ST, and the phase ends when HREADYOUT rises.
  assign dp_done = valid_q & hreadyout;
  assign rd_done = dp_done & ~write_q;
  // Gate with reset so a reset edge aborts a pending write.
  assign mem_we  = dp_done & write_q & ~HRESETn;

  always_ff @(posedge HCLK) begin
    if (HRESETn) begin
      state_q      <= OKAY_ST;
      valid_q      <= 1'b0;
      write_q      <= 1'b0;
      size_q       <= WORD;
      addr_q       <= '0;
      rdata_hold_q <= '0;
    end else begin
      state_q <= state_d;
      if (ahb.HREADY) begin
        valid_q <= accept & ~xfer_err;
        if (accept & ~xfer_err) begin
          addr_q  <= ahb.HADDR[IDX_W+1:0];
          write_q <= ahb.HWRITE;
          size_q  <= hsize_e'(ahb.HSIZE);
        end
      end
      if (rd_done) rdata_hold_q <= mem_rdata;
    end
  end

  modport_ahb_mem #(
    .MEM_DEPTH(MEM_DEPTH)
  ) u_mem (
    .clk_i  (HCLK),
    .we_i   (mem_we),
    .be_i   (byte_lanes(size_q, addr_q[1:0])),
    .idx_i  (addr_q[IDX_W+1:2]),
    .wdata_i(ahb.HWDATA),
    .rdata_o(mem_rdata)
  );

  // Live RAM word during a completing read, otherwise the last value returned.
  assign ahb.HRDATA    = rd_done ? mem_rdata : rdata_hold_q;
  assign ahb.HREADYOUT = hreadyout;
  assign ahb.HRESP     = hresp;

endmodule

// File: tb/tb_modport_ahb_slave.sv
// -----------------------------------------------------------------------------
// tb_modport_ahb_slave
// Drives AHB transfers into modport_ahb_slave; a byte-array reference memory
// predicts each data-phase response, which a monitor process compares against
// the bus. Honours MODPORT_AHB_SLAVE_WAIT_STATE_EN for the expected wait count.
// -----------------------------------------------------------------------------
module tb_modport_ahb_slave;

`ifdef MODPORT_AHB_SLAVE_WAIT_STATE_EN
  localparam int OKW = 1;
`else
  localparam int OKW = 0;
`endif

  typedef struct {
    bit          err;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst;
  modport_ahb_slave_if #(.HADDR_SIZE(32), .HDATA_SIZE(32)) ahb ();

  modport_ahb_slave #(
    .HADDR_SIZE(32),
    .HDATA_SIZE(32),
    .MEM_DEPTH (256)
  ) dut (
    .HCLK   (clk),
    .HRESETn(rst),
    .ahb    (ahb)
  );

  assign ahb.HREADY = ahb.HREADYOUT;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  exp_t        sbq[$];
  logic [7:0]  mem_m [1024];
  logic [31:0] wdata_pend = '0;
  bit          mon_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit ref_err(input logic [2:0] size, input logic [31:0] addr);
    int unsigned nb;
    if (size > 3'd2) return 1'b1;
    nb = 1 << size;
    if ((addr % nb) != 0) return 1'b1;
    if (addr >= 32'd1024) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] addr);
    int unsigned a;
    a = addr & ~32'd3;
    return {mem_m[a+3], mem_m[a+2], mem_m[a+1], mem_m[a]};
  endfunction

  // One address phase, entered and left at negedge+1; held while HREADY is low.
  task automatic beat(input logic sel, input logic [1:0] trans, input logic wr,
                      input logic [2:0] size, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [2:0] burst);
    int   n;
    exp_t e;
    ahb.HSELx  = sel;
    ahb.HTRANS = trans;
    ahb.HWRITE = wr;
    ahb.HSIZE  = size;
    ahb.HADDR  = addr;
    ahb.HBURST = burst;
    ahb.HPROT  = 4'($urandom);
    ahb.HWDATA = wdata_pend;
    n = 0;
    while (ahb.HREADYOUT !== 1'b1 && n < 8) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 8) chk("hready_timeout", 32'(ahb.HREADYOUT), 32'd1);
    wdata_pend = $urandom;
    if (sel && trans[1]) begin
      e.err  = ref_err(size, addr);
      e.rd   = !wr;
      e.data = '0;
      if (!e.err && !wr) e.data = ref_word(addr);
      if (!e.err && wr) begin
        for (int unsigned b = 0; b < (32'd1 << size); b++)
          mem_m[addr + b] = wdata[8*((addr + b) % 4) +: 8];
      end
      if (wr) wdata_pend = wdata;
      sbq.push_back(e);
    end
    @(negedge clk); #1;
  endtask

  task automatic idle_beat();
    beat(1'b0, 2'd0, 1'b0, 3'd2, 32'h0, 32'h0, 3'd0);
  endtask

  // Monitor: classifies each cycle from the bus alone and checks responses.
  initial begin
    exp_t cur;
    bit   rdy_prev, dp, acc;
    int   waits;
    cur.err = 0; cur.rd = 0; cur.data = '0;
    wait (mon_en);
    rdy_prev = 1'b1;
    dp = 1'b0;
    waits = 0;
    forever begin
      @(negedge clk);
      acc = rdy_prev && ahb.HSELx && ahb.HTRANS[1];
      if (acc) begin
        if (sbq.size() == 0) begin
          chk("sb_underflow", 32'd0, 32'd1);
          dp = 1'b0;
        end else begin
          cur = sbq.pop_front();
          dp = 1'b1;
          waits = 0;
        end
      end else if (rdy_prev) begin
        dp = 1'b0;
      end
      if (dp) begin
        if (ahb.HREADYOUT !== 1'b1) begin
          waits++;
          chk("wait_resp", 32'(ahb.HRESP), 32'(cur.err));
          if (waits > 2) begin
            chk("wait_bound", 32'(waits), 32'd2);
            dp = 1'b0;
          end
        end else begin
          chk("resp", 32'(ahb.HRESP), 32'(cur.err));
          chk("waits", 32'(waits), cur.err ? 32'd1 : 32'(OKW));
          if (cur.rd && !cur.err) chk("rdata", ahb.HRDATA, cur.data);
        end
      end else begin
        chk("idle_ready", 32'(ahb.HREADYOUT), 32'd1);
        chk("idle_resp", 32'(ahb.HRESP), 32'd0);
      end
      rdy_prev = ahb.HREADYOUT;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  sz;
    ahb.HSELx = 0; ahb.HTRANS = 0; ahb.HWRITE = 0; ahb.HSIZE = 3'd2;
    ahb.HADDR = 0; ahb.HBURST = 0; ahb.HPROT = 0; ahb.HWDATA = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_hreadyout", 32'(ahb.HREADYOUT), 32'd1);
    chk("rst_hresp", 32'(ahb.HRESP), 32'd0);
    chk("rst_hrdata", ahb.HRDATA, 32'd0);
    rst = 1'b0;
    mon_en = 1;

    // Fill the whole RAM so every later read has a known expectation.
    for (int unsigned i = 0; i < 256; i++)
      beat(1'b1, (i == 0) ? 2'd2 : 2'd3, 1'b1, 3'd2, i * 4, $urandom, 3'd1);
    idle_beat();

    beat(1'b1, 2'd2, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 3'd0);
    beat(1'b1, 2'd2, 1'b0, 3'd2, 32'h10, 32'h0, 3'd0);
    beat(1'b1, 2'd2, 1'b1, 3'd2, 32'h20, 32'h11223344, 3'd0);
    beat(1'b1, 2'd2, 1'b1, 3'd0, 32'h21, 32'h0000AA00, 3'd0);
    beat(1'b1, 2'd2, 1'b0, 3'd2, 32'h20, 32'h0, 3'd0);
    beat(1'b1, 2'd2, 1'b1, 3'd1, 32'h22, 32'hBEEF0000, 3'd0);
    beat(1'b1, 2'd2, 1'b0, 3'd2, 32'h20, 32'h0, 3'd0);
    // Error cases, each followed by a read proving memory is untouched
    beat(1'b1, 2'd2, 1'b0, 3'd2, 32'h3, 32'h0, 3'd0);
    beat(1'b1, 2'd2, 1'b1, 3'd2, 32'h12, 32'hFFFFFFFF, 3'd0);
    beat(1'b1, 2'd2, 1'b0, 3'd2, 32'h10, 32'h0, 3'd0);
    beat(1'b1, 2'd2, 1'b1, 3'd2, 32'h400, 32'h12345678, 3'd0);
    beat(1'b1, 2'd2, 1'b1, 3'd3, 32'h0, 32'hCAFEF00D, 3'd0);
    beat(1'b1, 2'd2, 1'b0, 3'd2, 32'h0, 32'h0, 3'd0);
    idle_beat();
    // INCR4 burst with a BUSY beat
    beat(1'b1, 2'd2, 1'b1, 3'd2, 32'h40, 32'd1, 3'd3);
    beat(1'b1, 2'd3, 1'b1, 3'd2, 32'h44, 32'd2, 3'd3);
    beat(1'b1, 2'd1, 1'b1, 3'd2, 32'h48, 32'hFFFFFFFF, 3'd3);
    beat(1'b1, 2'd3, 1'b1, 3'd2, 32'h48, 32'd3, 3'd3);
    beat(1'b1, 2'd3, 1'b1, 3'd2, 32'h4C, 32'd4, 3'd3);
    beat(1'b1, 2'd0, 1'b1, 3'd2, 32'h40, 32'hFFFFFFFF, 3'd0);
    beat(1'b0, 2'd2, 1'b1, 3'd2, 32'h44, 32'hFFFFFFFF, 3'd0);
    for (int unsigned i = 0; i < 4; i++)
      beat(1'b1, (i == 0) ? 2'd2 : 2'd3, 1'b0, 3'd2, 32'h40 + i * 4, 32'h0, 3'd3);
    idle_beat();

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      sz = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      a  = ($urandom_range(0, 9) == 0) ? $urandom_range(1024, 1100) : $urandom_range(0, 1023);
      if (sz <= 3'd2 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      beat(1'($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), 1'($urandom),
           sz, a, $urandom, 3'($urandom));
    end
    repeat (4) idle_beat();

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
